// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 4-stage pipeline sequencer with stall/flush control, debug run/halt/step FSM and saturating perf counters.
module pipe_ctrl #(
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_req,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             dhs,
  input  logic             br_dec,
  input  logic             cnt_clr,
  output logic             en_pc,
  output logic             en_if,
  output logic             en_dec,
  output logic             en_ex,
  output logic             bub_dec,
  output logic             flush_if,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [2:0] {RUN = 3'd0, STALL = 3'd1, BRANCH = 3'd2, HALT = 3'd3, STEP = 3'd4} state_t;
  localparam logic [2:0] FC_INIT = 3'(FLUSH_CYC - 1);
  localparam bit MULTI = FLUSH_CYC > 1;
  localparam logic [CNT_W-1:0] CMAX = '1;
  state_t state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic pend_q, pend_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic dec, stall_p, flush_p, halt_nxt;
  always_comb begin
    dec      = state_q inside {RUN, STALL, STEP};
    stall_p  = reset && dec && dhs;
    flush_p  = reset && (state_q == BRANCH || (dec && !dhs && br_dec));
    en_dec   = reset && state_q != HALT;
    en_ex    = en_dec;
    en_pc    = en_dec && !stall_p;
    en_if    = en_pc;
    bub_dec  = stall_p;
    flush_if = flush_p;
    halted   = state_q == HALT;
    state    = state_q;
    stall_cnt = stall_q;
    flush_cnt = flush_q;
    // a step always returns to HALT after its single decision cycle
    halt_nxt = state_q == STEP || halt_req;
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    pend_d   = pend_q;
    if (state_q == HALT) begin
      state_d = run_req ? RUN : step_req ? STEP : HALT;
    end else if (state_q == BRANCH) begin
      fcnt_d = fcnt_q - 3'd1;
      pend_d = pend_q || halt_req;
      if (fcnt_q == 3'd1) begin
        state_d = (pend_q || halt_req) ? HALT : RUN;
        pend_d  = 1'b0;
      end
    end else if (!dhs && br_dec) begin
      fcnt_d = FC_INIT;
      if (MULTI) begin
        state_d = BRANCH;
        pend_d  = halt_nxt;
      end else begin
        state_d = halt_nxt ? HALT : RUN;
      end
    end else begin
      state_d = halt_nxt ? HALT : dhs ? STALL : RUN;
    end
    stall_d = cnt_clr ? '0 : (stall_p && stall_q != CMAX) ? stall_q + 1'b1 : stall_q;
    flush_d = cnt_clr ? '0 : (flush_p && flush_q != CMAX) ? flush_q + 1'b1 : flush_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed plus randomized checks of pipe_ctrl against a behavioural model.
module tb_pipe_ctrl;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0, reset = 1'b0;
  logic halt_req = 0, run_req = 0, step_req = 0, dhs = 0, br_dec = 0, cnt_clr = 0;
  logic en_pc, en_if, en_dec, en_ex, bub_dec, flush_if, halted;
  logic [2:0] state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int checks = 0, errors = 0;
  int m_st = 0, m_left = 0, m_sc = 0, m_fc = 0;
  bit m_pend = 0;

  pipe_ctrl #(.FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .halt_req(halt_req), .run_req(run_req), .step_req(step_req),
    .dhs(dhs), .br_dec(br_dec), .cnt_clr(cnt_clr), .en_pc(en_pc), .en_if(en_if),
    .en_dec(en_dec), .en_ex(en_ex), .bub_dec(bub_dec), .flush_if(flush_if),
    .halted(halted), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {en_pc, en_if, en_dec, en_ex, bub_dec, flush_if}
  function automatic logic [5:0] exp_pat();
    if (!reset || m_st == 3) return 6'b000000;
    if (m_st == 2) return 6'b111101;
    if (dhs) return 6'b001110;
    return br_dec ? 6'b111101 : 6'b111100;
  endfunction

  task automatic model_step(input logic [5:0] p);
    bit stop;
    if (!reset) begin
      m_st = 0; m_left = 0; m_pend = 0; m_sc = 0; m_fc = 0;
      return;
    end
    m_sc = cnt_clr ? 0 : (p[1] && m_sc < CMAX) ? m_sc + 1 : m_sc;
    m_fc = cnt_clr ? 0 : (p[0] && m_fc < CMAX) ? m_fc + 1 : m_fc;
    if (m_st == 3) begin
      m_st = run_req ? 0 : step_req ? 4 : 3;
    end else if (m_st == 2) begin
      m_left--;
      if (halt_req) m_pend = 1;
      if (m_left == 0) begin
        m_st = m_pend ? 3 : 0;
        m_pend = 0;
      end
    end else begin
      stop = (m_st == 4) || halt_req;
      if (dhs) m_st = stop ? 3 : 1;
      else if (br_dec) begin
        m_left = FLUSH_CYC - 1;
        if (m_left > 0) begin
          m_st = 2;
          m_pend = stop;
        end else m_st = stop ? 3 : 0;
      end else m_st = stop ? 3 : 0;
    end
  endtask

  task automatic tick();
    logic [5:0] p;
    #2;
    p = exp_pat();
    chk("pattern", 16'({en_pc, en_if, en_dec, en_ex, bub_dec, flush_if}), 16'(p));
    @(posedge clk);
    model_step(p);
    #1;
    chk("state", 16'(state), 16'(m_st));
    chk("halted", 16'(halted), 16'(m_st == 3));
    chk("stall_cnt", 16'(stall_cnt), 16'(m_sc));
    chk("flush_cnt", 16'(flush_cnt), 16'(m_fc));
  endtask

  initial begin
    repeat (2) tick();
    reset = 1;
    repeat (5) tick();
    dhs = 1; repeat (3) tick();
    dhs = 0; repeat (2) tick();
    br_dec = 1; tick();
    br_dec = 0; dhs = 1; tick();
    dhs = 0; tick();
    br_dec = 1; halt_req = 1; tick();
    br_dec = 0; halt_req = 0; repeat (3) tick();
    run_req = 1; tick();
    run_req = 0; tick();
    halt_req = 1; tick();
    halt_req = 0;
    repeat (3) begin
      step_req = 1; tick();
      step_req = 0; repeat (3) tick();
    end
    step_req = 1; tick();
    step_req = 0; dhs = 1; tick();
    dhs = 0; repeat (2) tick();
    step_req = 1; tick();
    step_req = 0; br_dec = 1; tick();
    br_dec = 0; repeat (3) tick();
    run_req = 1; tick();
    run_req = 0; cnt_clr = 1; tick();
    cnt_clr = 0; dhs = 1; repeat (17) tick();
    cnt_clr = 1; tick();
    cnt_clr = 0; dhs = 0; tick();
    br_dec = 1; tick();
    br_dec = 0; reset = 0; repeat (2) tick();
    reset = 1; tick();
    repeat (400) begin
      dhs      = $urandom_range(0, 3) == 0;
      br_dec   = $urandom_range(0, 4) == 0;
      halt_req = $urandom_range(0, 9) == 0;
      run_req  = $urandom_range(0, 3) == 0;
      step_req = $urandom_range(0, 2) == 0;
      cnt_clr  = $urandom_range(0, 39) == 0;
      reset    = $urandom_range(0, 59) != 0;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
